// File: rtl/pen_locator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pen_locator_pkg                                                          |
// | Shared FSM encodings, matrix geometry and one-hot decode helper.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pen_locator_pkg;

  localparam int MATRIX_DIM = 8;
  localparam int IDX_W      = 6;
  localparam int COORD_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_PROBE  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  function automatic logic [MATRIX_DIM-1:0] one_hot(input logic [COORD_W-1:0] sel);
    logic [MATRIX_DIM-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage : pen_locator_pkg
`default_nettype wire

// File: rtl/pen_locator_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pen_locator_sync                                                         |
// | Two-flop synchronizer for the asynchronous light-pen sense input.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pen_locator_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule : pen_locator_sync
`default_nettype wire

// File: rtl/pen_locator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pen_locator                                                              |
// | Sweeps the 8x8 matrix one pixel at a time and reports the first pixel    |
// | the light pen sees, borrowing the matrix from led_driver via req/gnt.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pen_locator
  import pen_locator_pkg::*;
#(
  parameter int DWELL_CYC  = 5000,
  parameter int SETTLE_CYC = 2000,
  parameter int HIT_MIN    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pen_i,
  output logic                  scan_req,
  input  logic                  scan_gnt,
  output logic [MATRIX_DIM-1:0] probe_row,
  output logic [MATRIX_DIM-1:0] probe_col,
  output logic [COORD_W-1:0]    pos_x,
  output logic [COORD_W-1:0]    pos_y,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic                  miss,
  output logic                  abort,
  output logic                  busy
);

  localparam int DW_W  = $clog2(DWELL_CYC);
  localparam int HIT_W = $clog2(DWELL_CYC - SETTLE_CYC + 1);

  localparam logic [DW_W-1:0]  c_dwell_last = DW_W'(DWELL_CYC - 1);
  localparam logic [DW_W-1:0]  c_settle     = DW_W'(SETTLE_CYC);
  localparam logic [HIT_W-1:0] c_hit_max    = HIT_W'(DWELL_CYC - SETTLE_CYC);
  localparam logic [HIT_W-1:0] c_hit_min    = HIT_W'(HIT_MIN);
  localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(MATRIX_DIM * MATRIX_DIM - 1);

  if (DWELL_CYC < 2 || SETTLE_CYC < 0 || SETTLE_CYC >= DWELL_CYC ||
      HIT_MIN < 1 || HIT_MIN > DWELL_CYC - SETTLE_CYC) begin : g_param_check
    $error("pen_locator: illegal DWELL_CYC/SETTLE_CYC/HIT_MIN combination");
  end

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [DW_W-1:0]    r_dwell_cnt;
  logic [HIT_W-1:0]   r_hit_cnt;
  logic               w_pen_s;
  logic               w_sample;
  logic               w_dwell_last;
  logic [HIT_W-1:0]   w_hit_next;
  logic               w_hit;
  logic               w_lit;

  pen_locator_sync u_pen_sync (
    .clk (clk),
    .rst (rst),
    .d   (pen_i),
    .q   (w_pen_s)
  );

  // Samples before SETTLE_CYC are discarded while the phototransistor rises.
  assign w_sample     = (r_dwell_cnt >= c_settle) && w_pen_s;
  assign w_dwell_last = (r_dwell_cnt == c_dwell_last);
  assign w_hit_next   = (w_sample && (r_hit_cnt != c_hit_max)) ? r_hit_cnt + 1'b1 : r_hit_cnt;
  assign w_hit        = (w_hit_next >= c_hit_min);

  // Gated by scan_gnt so the panel goes dark in the very cycle the grant is lost.
  assign w_lit     = (r_state == ST_PROBE) && scan_gnt;
  assign probe_row = w_lit ? one_hot(r_idx[IDX_W-1:COORD_W]) : '0;
  assign probe_col = w_lit ? one_hot(r_idx[COORD_W-1:0])     : '0;
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_dwell_cnt <= '0;
      r_hit_cnt   <= '0;
      scan_req    <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      pos_valid   <= 1'b0;
      miss        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      miss  <= 1'b0;
      abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            scan_req <= 1'b1;
            r_state  <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (scan_gnt) begin
            r_idx       <= '0;
            r_dwell_cnt <= '0;
            r_hit_cnt   <= '0;
            r_state     <= ST_PROBE;
          end
        end

        ST_PROBE: begin
          if (!scan_gnt) begin
            abort    <= 1'b1;
            scan_req <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_dwell_last) begin
            if (w_hit) begin
              pos_x     <= r_idx[COORD_W-1:0];
              pos_y     <= r_idx[IDX_W-1:COORD_W];
              pos_valid <= 1'b1;
              scan_req  <= 1'b0;
              r_state   <= ST_REPORT;
            end else if (r_idx == c_idx_last) begin
              miss     <= 1'b1;
              scan_req <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_idx       <= r_idx + 1'b1;
              r_dwell_cnt <= '0;
              r_hit_cnt   <= '0;
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
            r_hit_cnt   <= w_hit_next;
          end
        end

        ST_REPORT: begin
          if (pos_ready) begin
            pos_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : pen_locator
`default_nettype wire
